// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - ALU op encodings, flag bit indices and queued command layout
package alu_pkg;

    typedef enum logic [2:0] {
        OP_NOTA = 3'b000,
        OP_NOTB = 3'b001,
        OP_AND  = 3'b010,
        OP_OR   = 3'b011,
        OP_XOR  = 3'b100,
        OP_XNOR = 3'b101,
        OP_ADD  = 3'b110,
        OP_SUB  = 3'b111
    } alu_op_e;

    // Flag vector is {c,n,z,v}
    localparam int FLAG_C = 3;
    localparam int FLAG_N = 2;
    localparam int FLAG_Z = 1;
    localparam int FLAG_V = 0;

    localparam int CMD_W = 68;

    typedef struct packed {
        logic        use_acc;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
    } alu_cmd_t;

endpackage

// File: rtl/alu_cmd_fifo.sv
// rtl/alu_cmd_fifo.sv - DEPTH-entry synchronous command FIFO with empty flag and occupancy count
module alu_cmd_fifo
    import alu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          push,
    input  alu_cmd_t      push_data,
    input  logic          pop,
    output alu_cmd_t      head,
    output logic          empty,
    output logic [AW:0]   count
);

    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    alu_cmd_t    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q, count_d;
    logic          push_en, pop_en;

    assign empty   = (count_q == '0);
    assign push_en = push && (count_q != FULL_CNT);
    assign pop_en  = pop && !empty;
    assign head    = mem_q[rd_ptr_q];
    assign count   = count_q;

    always_comb begin
        count_d = count_q;
        case ({push_en, pop_en})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Storage carries no reset; readers gate the head with empty
    always_ff @(posedge clk) begin
        if (push_en) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_en) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_en)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/alu32_issue_stage.sv
// rtl/alu32_issue_stage.sv - queues ALU commands, issues one per cycle, registers result/flags/accumulator
// Optional ALU_STICKY_OVF_EN adds a sticky overflow bit with sticky_v/sticky_clr ports.
module alu32_issue_stage
    import alu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [2:0]  cmd_op,
    input  logic [31:0] cmd_a,
    input  logic [31:0] cmd_b,
    input  logic        cmd_use_acc,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [2:0]  alu_op,
    input  logic [31:0] alu_result,
    input  logic        alu_c,
    input  logic        alu_n,
    input  logic        alu_z,
    input  logic        alu_v,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic [3:0]  out_flags,
    output logic [31:0] acc
`ifdef ALU_STICKY_OVF_EN
    ,
    output logic        sticky_v,
    input  logic        sticky_clr
`endif
);

    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    alu_cmd_t    push_cmd, head;
    logic        fifo_empty;
    logic [AW:0] fifo_count;
    logic        issue;

    logic        out_valid_q;
    logic [31:0] out_result_q;
    logic [3:0]  out_flags_q;
    logic [31:0] acc_q;

    assign push_cmd  = {cmd_use_acc, cmd_op, cmd_a, cmd_b};
    // Depends only on occupancy, so out_ready never reaches cmd_ready combinationally
    assign cmd_ready = (fifo_count != FULL_CNT);
    assign issue     = !fifo_empty && (!out_valid_q || out_ready);

    alu_cmd_fifo #(.DEPTH(DEPTH), .AW(AW)) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (cmd_valid && cmd_ready),
        .push_data (push_cmd),
        .pop       (issue),
        .head      (head),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_comb begin
        alu_a  = '0;
        alu_b  = '0;
        alu_op = '0;
        if (!fifo_empty) begin
            alu_a  = head.use_acc ? acc_q : head.a;
            alu_b  = head.b;
            alu_op = head.op;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            out_flags_q  <= '0;
            acc_q        <= '0;
        end else if (issue) begin
            out_valid_q  <= 1'b1;
            out_result_q <= alu_result;
            out_flags_q  <= {alu_c, alu_n, alu_z, alu_v};
            acc_q        <= alu_result;
        end else if (out_ready) begin
            out_valid_q  <= 1'b0;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_result = out_result_q;
    assign out_flags  = out_flags_q;
    assign acc        = acc_q;

`ifdef ALU_STICKY_OVF_EN
    logic sticky_v_q;

    // An overflow issuing in the same cycle as a clear keeps the bit set
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sticky_v_q <= 1'b0;
        end else if (issue && alu_v) begin
            sticky_v_q <= 1'b1;
        end else if (sticky_clr) begin
            sticky_v_q <= 1'b0;
        end
    end

    assign sticky_v = sticky_v_q;
`endif

endmodule

// File: tb/tb_alu32_issue_stage.sv
// tb/tb_alu32_issue_stage.sv - directed table-driven bench for alu32_issue_stage with a behavioural ALU
module tb_alu32_issue_stage;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cmd_valid = 1'b0, cmd_ready, cmd_use_acc = 1'b0;
    logic [2:0]  cmd_op = '0;
    logic [31:0] cmd_a = '0, cmd_b = '0;
    logic [31:0] alu_a, alu_b, alu_result;
    logic [2:0]  alu_op;
    logic        alu_c, alu_n, alu_z, alu_v;
    logic        out_valid, out_ready = 1'b1;
    logic [31:0] out_result, acc;
    logic [3:0]  out_flags;
    logic        sticky_v, sticky_clr = 1'b0;
    logic [32:0] alu_sum;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    alu32_issue_stage dut (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_use_acc(cmd_use_acc),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result),
        .alu_c(alu_c), .alu_n(alu_n), .alu_z(alu_z), .alu_v(alu_v),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_flags(out_flags), .acc(acc)
`ifdef ALU_STICKY_OVF_EN
        , .sticky_v(sticky_v), .sticky_clr(sticky_clr)
`endif
    );

    // Behavioural ALU: c/v meaningful for add/sub only, sub carry = carry out of a + ~b + 1
    always_comb begin
        alu_sum    = '0;
        alu_result = '0;
        alu_c      = 1'b0;
        alu_v      = 1'b0;
        case (alu_op)
            3'b000: alu_result = ~alu_a;
            3'b001: alu_result = ~alu_b;
            3'b010: alu_result = alu_a & alu_b;
            3'b011: alu_result = alu_a | alu_b;
            3'b100: alu_result = alu_a ^ alu_b;
            3'b101: alu_result = ~(alu_a ^ alu_b);
            3'b110: begin
                alu_sum    = {1'b0, alu_a} + {1'b0, alu_b};
                alu_result = alu_sum[31:0];
                alu_c      = alu_sum[32];
                alu_v      = (alu_a[31] == alu_b[31]) && (alu_sum[31] != alu_a[31]);
            end
            default: begin
                alu_sum    = {1'b0, alu_a} + {1'b0, ~alu_b} + 33'd1;
                alu_result = alu_sum[31:0];
                alu_c      = alu_sum[32];
                alu_v      = (alu_a[31] != alu_b[31]) && (alu_sum[31] != alu_a[31]);
            end
        endcase
        alu_n = alu_result[31];
        alu_z = (alu_result == 32'd0);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Called at a negedge with an empty FIFO; returns at the negedge where out_valid was seen
    task automatic run_cmd(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic ua, output int lat);
        cmd_op = op; cmd_a = a; cmd_b = b; cmd_use_acc = ua; cmd_valid = 1'b1;
        @(posedge clk); @(negedge clk);
        cmd_valid = 1'b0; cmd_use_acc = 1'b0;
        lat = 1;
        while (!out_valid && lat < 8) begin
            @(negedge clk);
            lat++;
        end
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic        ua;
        logic [31:0] exp_r;
        logic [3:0]  exp_f;
    } vec_t;

    vec_t vecs[13];
    logic [31:0] exp_q[$];

    initial begin
        int lat;
        int got, first_cyc, last_cyc;
        bit order_ok, ready_ok;

        vecs[0]  = '{3'b110, 32'd5,          32'd3,          1'b0, 32'd8,          4'b0000};
        vecs[1]  = '{3'b111, 32'd0,          32'd1,          1'b0, 32'hFFFF_FFFF,  4'b0100};
        vecs[2]  = '{3'b110, 32'd0,          32'd1,          1'b1, 32'd0,          4'b1010};
        vecs[3]  = '{3'b110, 32'h7FFF_FFFF,  32'd1,          1'b0, 32'h8000_0000,  4'b0101};
        vecs[4]  = '{3'b000, 32'h0F0F_0000,  32'd0,          1'b0, 32'hF0F0_FFFF,  4'b0100};
        vecs[5]  = '{3'b001, 32'd7,          32'hFFFF_FFFF,  1'b0, 32'd0,          4'b0010};
        vecs[6]  = '{3'b010, 32'hA5A5_A5A5,  32'h0F0F_0F0F,  1'b0, 32'h0505_0505,  4'b0000};
        vecs[7]  = '{3'b011, 32'h8000_0000,  32'd1,          1'b0, 32'h8000_0001,  4'b0100};
        vecs[8]  = '{3'b100, 32'h1234,       32'h1234,       1'b0, 32'd0,          4'b0010};
        vecs[9]  = '{3'b101, 32'd0,          32'd0,          1'b0, 32'hFFFF_FFFF,  4'b0100};
        vecs[10] = '{3'b111, 32'd5,          32'd3,          1'b0, 32'd2,          4'b1000};
        vecs[11] = '{3'b111, 32'h8000_0000,  32'd1,          1'b0, 32'h7FFF_FFFF,  4'b1001};
        vecs[12] = '{3'b111, 32'd0,          32'h7FFF_FFFF,  1'b1, 32'd0,          4'b1010};

        repeat (2) @(negedge clk);
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_result", out_result, 0);
        chk("rst_out_flags", out_flags, 0);
        chk("rst_acc", acc, 0);
        chk("rst_alu_drive", {alu_op, alu_a, alu_b}, 0);
`ifdef ALU_STICKY_OVF_EN
        chk("rst_sticky", sticky_v, 0);
`endif
        reset_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 13; i++) begin
            run_cmd(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].ua, lat);
            chk($sformatf("v%0d_latency", i), lat, 2);
            chk($sformatf("v%0d_result", i), out_result, vecs[i].exp_r);
            chk($sformatf("v%0d_flags", i), out_flags, vecs[i].exp_f);
            chk($sformatf("v%0d_acc", i), acc, vecs[i].exp_r);
            @(negedge clk);
            chk($sformatf("v%0d_valid_drop", i), out_valid, 0);
        end

`ifdef ALU_STICKY_OVF_EN
        chk("sticky_held", sticky_v, 1);
        sticky_clr = 1'b1;
        @(negedge clk);
        sticky_clr = 1'b0;
        chk("sticky_cleared", sticky_v, 0);
        sticky_clr = 1'b1;
        run_cmd(3'b110, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0, lat);
        sticky_clr = 1'b0;
        chk("sticky_set_wins", sticky_v, 1);
        sticky_clr = 1'b1;
        @(negedge clk);
        sticky_clr = 1'b0;
        chk("sticky_cleared2", sticky_v, 0);
`endif

        // Backpressure: one result held in the output register, four queued
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("bp_ready_%0d", i), cmd_ready, 1);
            cmd_op = 3'b110; cmd_a = 32'd100 + 32'(i); cmd_b = 32'd0; cmd_valid = 1'b1;
            @(posedge clk); @(negedge clk);
        end
        cmd_a = 32'd999;
        chk("bp_full_ready", cmd_ready, 0);
        @(posedge clk); @(negedge clk);
        cmd_valid = 1'b0;
        chk("bp_still_full", cmd_ready, 0);
        chk("bp_hold_result", {31'd0, out_valid, out_result}, {31'd0, 1'b1, 32'd100});
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("bp_out_%0d", i), {31'd0, out_valid, out_result},
                {31'd0, 1'b1, 32'd100 + 32'(i)});
            @(posedge clk); @(negedge clk);
            if (i == 0) chk("bp_ready_back", cmd_ready, 1);
        end
        chk("bp_drained", out_valid, 0);

        // Reset while three commands are queued and a result is held
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cmd_op = 3'b110; cmd_a = 32'd50; cmd_b = 32'(i); cmd_valid = 1'b1;
            @(posedge clk); @(negedge clk);
        end
        cmd_valid = 1'b0;
        chk("mid_pre_valid", out_valid, 1);
        #2 reset_n = 1'b0;
        #1;
        chk("mid_out_valid", out_valid, 0);
        chk("mid_cmd_ready", cmd_ready, 1);
        chk("mid_acc", acc, 0);
        chk("mid_out_result", out_result, 0);
        chk("mid_alu_drive", {alu_op, alu_a, alu_b}, 0);
        @(negedge clk);
        reset_n = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        run_cmd(3'b110, 32'hDEAD, 32'd4, 1'b1, lat);
        chk("post_rst_latency", lat, 2);
        chk("post_rst_result", out_result, 4);
        @(negedge clk);
        chk("post_rst_empty", out_valid, 0);

        // Streaming: 16 back-to-back commands with out_ready held high
        got = 0; first_cyc = -1; last_cyc = -1; order_ok = 1; ready_ok = 1;
        for (int i = 0; i < 16; i++) exp_q.push_back(32'(2 * i));
        for (int cyc = 0; cyc < 24; cyc++) begin
            if (out_valid) begin
                if (first_cyc < 0) first_cyc = cyc;
                last_cyc = cyc;
                if (exp_q.size() == 0 || out_result != exp_q.pop_front()) order_ok = 0;
                got++;
            end
            if (cyc < 16) begin
                if (!cmd_ready) ready_ok = 0;
                cmd_op = 3'b110; cmd_a = 32'(cyc); cmd_b = 32'(cyc); cmd_valid = 1'b1;
            end else begin
                cmd_valid = 1'b0;
            end
            @(posedge clk); @(negedge clk);
        end
        chk("stream_count", got, 16);
        chk("stream_order", order_ok, 1);
        chk("stream_ready", ready_ok, 1);
        chk("stream_first", first_cyc, 2);
        chk("stream_no_bubble", last_cyc - first_cyc, 15);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
